// File: rtl/seg7_scan_if.sv
// seg7_scan_if: digit select, load strobe/data and active-low pin bundle of the 4-digit scan driver
interface seg7_scan_if;
    logic [1:0]  digit_sel;
    logic        load_req;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        load_pending;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    modport master(output digit_sel, load_req, data_in, dp_in, input load_pending, an, seg, dp);
    modport slave(input digit_sel, load_req, data_in, dp_in, output load_pending, an, seg, dp);
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: tear-free 4-digit hex scan driver with anti-ghosting blank on every digit change
// SEG7_LZ_BLANK_EN defined: leading zeros (without dp) on digits 3..1 are kept dark.
module seg7_scan_driver #(
    parameter int BLANK_CYCLES = 16
) (
    input logic         clk,
    input logic         rst_n,
    seg7_scan_if.slave  bus
);
    localparam int BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYCLES);

    logic [1:0]    sel_q;
    logic [BW-1:0] blank_cnt;
    logic [19:0]   shadow;
    logic [15:0]   disp;
    logic [3:0]    disp_dp;
    logic          change;
    logic          commit;
    logic          off;
    logic [3:0]    lz;
    logic [3:0]    nib;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        change = bus.digit_sel != sel_q;
        commit = change && sel_q == 2'd3 && bus.digit_sel == 2'd0;
`ifdef SEG7_LZ_BLANK_EN
        lz = {disp[15:12] == 4'd0 && !disp_dp[3], disp[15:8] == 8'd0 && !disp_dp[2],
              disp[15:4] == 12'd0 && !disp_dp[1], 1'b0};
`else
        lz = 4'd0;
`endif
        off = change || blank_cnt != '0 || lz[sel_q];
        nib = disp[{sel_q, 2'b00} +: 4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q            <= 2'd0;
            blank_cnt        <= '0;
            shadow           <= 20'd0;
            disp             <= 16'd0;
            disp_dp          <= 4'd0;
            bus.load_pending <= 1'b0;
            bus.an           <= 4'hF;
            bus.seg          <= 7'h7F;
            bus.dp           <= 1'b1;
        end else begin
            sel_q     <= bus.digit_sel;
            blank_cnt <= change ? BLANK_LOAD : (blank_cnt != '0 ? blank_cnt - 1'b1 : blank_cnt);
            if (bus.load_req)
                shadow <= {bus.dp_in, bus.data_in};
            // commit uses the shadow as it was before this cycle's load
            if (commit && bus.load_pending)
                {disp_dp, disp} <= shadow;
            bus.load_pending <= bus.load_req | (bus.load_pending & ~commit);
            bus.an           <= off ? 4'hF : ~(4'b0001 << sel_q);
            bus.seg          <= off ? 7'h7F : hex7(nib);
            bus.dp           <= off ? 1'b1 : ~disp_dp[sel_q];
        end
    end
endmodule
